// File: rtl/cdb_arbiter.sv
// Two-source (ALU / LSB) result queues arbitrated onto a registered common data bus.
// Define CDB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed LSB priority.
module cdb_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        rollback,
  input  logic        alu_result,
  input  logic [3:0]  alu_result_rob_pos,
  input  logic [31:0] alu_result_val,
  input  logic        lsb_result,
  input  logic [3:0]  lsb_result_rob_pos,
  input  logic [31:0] lsb_result_val,
  output logic        alu_full,
  output logic        lsb_full,
  output logic        cdb_valid,
  output logic [3:0]  cdb_rob_pos,
  output logic [31:0] cdb_val,
  output logic        cdb_src,
  output logic        ovf
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = 36;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic          enable;
  logic [1:0]    push_in;
  logic [1:0]    full;
  logic [1:0]    not_empty;
  logic [1:0]    drop;
  logic [EW-1:0] wdata [2];
  logic [EW-1:0] head_data [2];
  logic          grant_valid;
  logic          grant_src;

  logic          cdb_valid_q, cdb_valid_d;
  logic [3:0]    cdb_rob_pos_q, cdb_rob_pos_d;
  logic [31:0]   cdb_val_q, cdb_val_d;
  logic          cdb_src_q, cdb_src_d;
  logic          ovf_q, ovf_d;
  logic          last_grant_q, last_grant_d;

  assign enable   = rdy && !rollback;
  assign push_in  = {lsb_result, alu_result};
  assign wdata[0] = {alu_result_rob_pos, alu_result_val};
  assign wdata[1] = {lsb_result_rob_pos, lsb_result_val};

  // Index 0 is the ALU queue, index 1 the LSB queue (matches cdb_src encoding).
  for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
    logic [EW-1:0] mem_q [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          pop;
    logic          push_ok;

    assign pop           = grant_valid && (grant_src == 1'(gi));
    assign full[gi]      = (count_q == FULL_CNT);
    assign not_empty[gi] = (count_q != '0);
    // A full queue still accepts a push on the cycle its head is popped.
    assign push_ok       = push_in[gi] && (!full[gi] || pop);
    assign drop[gi]      = push_in[gi] && !push_ok;
    assign head_data[gi] = mem_q[head_q];

    always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (rollback) begin
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
      end else begin
        if (pop)     head_d = head_q + PW'(1);
        if (push_ok) tail_d = tail_q + PW'(1);
        if (push_ok && !pop)      count_d = count_q + CW'(1);
        else if (pop && !push_ok) count_d = count_q - CW'(1);
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
      end else if (rdy) begin
        head_q  <= head_d;
        tail_q  <= tail_d;
        count_q <= count_d;
      end
    end

    always_ff @(posedge clk) begin
      if (!rst && enable && push_ok) mem_q[tail_q] <= wdata[gi];
    end
  end

  always_comb begin
    grant_valid = |not_empty;
`ifdef CDB_ROUND_ROBIN_EN
    grant_src = (&not_empty) ? ~last_grant_q : not_empty[1];
`else
    grant_src = not_empty[1];
`endif
  end

  always_comb begin
    cdb_valid_d   = cdb_valid_q;
    cdb_rob_pos_d = cdb_rob_pos_q;
    cdb_val_d     = cdb_val_q;
    cdb_src_d     = cdb_src_q;
    ovf_d         = ovf_q;
    last_grant_d  = last_grant_q;
    if (rollback) begin
      cdb_valid_d = 1'b0;
    end else begin
      cdb_valid_d = grant_valid;
      ovf_d       = ovf_q | (|drop);
      if (grant_valid) begin
        {cdb_rob_pos_d, cdb_val_d} = head_data[grant_src];
        cdb_src_d    = grant_src;
        last_grant_d = grant_src;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cdb_valid_q   <= 1'b0;
      cdb_rob_pos_q <= '0;
      cdb_val_q     <= '0;
      cdb_src_q     <= 1'b0;
      ovf_q         <= 1'b0;
      last_grant_q  <= 1'b1;
    end else if (rdy) begin
      cdb_valid_q   <= cdb_valid_d;
      cdb_rob_pos_q <= cdb_rob_pos_d;
      cdb_val_q     <= cdb_val_d;
      cdb_src_q     <= cdb_src_d;
      ovf_q         <= ovf_d;
      last_grant_q  <= last_grant_d;
    end
  end

  assign alu_full    = full[0];
  assign lsb_full    = full[1];
  assign cdb_valid   = cdb_valid_q;
  assign cdb_rob_pos = cdb_rob_pos_q;
  assign cdb_val     = cdb_val_q;
  assign cdb_src     = cdb_src_q;
  assign ovf         = ovf_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: stimulus queues expected per-source entries, a monitor pops them.
module tb_cdb_arbiter;

  logic        clk = 1'b0;
  logic        rst, rdy, rollback;
  logic        alu_result, lsb_result;
  logic [3:0]  alu_result_rob_pos, lsb_result_rob_pos;
  logic [31:0] alu_result_val, lsb_result_val;
  logic        alu_full, lsb_full, cdb_valid, cdb_src, ovf;
  logic [3:0]  cdb_rob_pos;
  logic [31:0] cdb_val;

  int n_checks = 0;
  int n_fail   = 0;

  logic [35:0] alu_q[$];
  logic [35:0] lsb_q[$];

`ifdef CDB_ROUND_ROBIN_EN
  localparam int          FILL_N    = 7;
  localparam logic [31:0] POP_POS   = 32'd3;
  localparam logic [31:0] FIRST_POS = 32'd1;
`else
  localparam int          FILL_N    = 4;
  localparam logic [31:0] POP_POS   = 32'd0;
  localparam logic [31:0] FIRST_POS = 32'd9;
`endif

  cdb_arbiter #(.DEPTH(4)) dut (
    .clk                (clk),
    .rst                (rst),
    .rdy                (rdy),
    .rollback           (rollback),
    .alu_result         (alu_result),
    .alu_result_rob_pos (alu_result_rob_pos),
    .alu_result_val     (alu_result_val),
    .lsb_result         (lsb_result),
    .lsb_result_rob_pos (lsb_result_rob_pos),
    .lsb_result_val     (lsb_result_val),
    .alu_full           (alu_full),
    .lsb_full           (lsb_full),
    .cdb_valid          (cdb_valid),
    .cdb_rob_pos        (cdb_rob_pos),
    .cdb_val            (cdb_val),
    .cdb_src            (cdb_src),
    .ovf                (ovf)
  );

  always #5 clk = ~clk;

  // Monitor: a new broadcast exists only after an enabled, non-reset edge.
  logic        mon_en;
  logic [35:0] mon_got, mon_exp;
  always begin
    @(posedge clk);
    mon_en = rdy && !rst;
    #1;
    if (mon_en && cdb_valid) begin
      mon_got = {cdb_rob_pos, cdb_val};
      $display("cdb broadcast src=%0d pos=%0d val=0x%0h", cdb_src, cdb_rob_pos, cdb_val);
      n_checks++;
      if (cdb_src == 1'b0) begin
        if (alu_q.size() == 0) begin
          n_fail++;
          $display("FAIL alu_unexpected: got pos=%0d val=0x%0h, required no ALU broadcast", cdb_rob_pos, cdb_val);
        end else begin
          mon_exp = alu_q.pop_front();
          if (mon_got !== mon_exp) begin
            n_fail++;
            $display("FAIL alu_order: got 0x%0h, required 0x%0h", mon_got, mon_exp);
          end
        end
      end else begin
        if (lsb_q.size() == 0) begin
          n_fail++;
          $display("FAIL lsb_unexpected: got pos=%0d val=0x%0h, required no LSB broadcast", cdb_rob_pos, cdb_val);
        end else begin
          mon_exp = lsb_q.pop_front();
          if (mon_got !== mon_exp) begin
            n_fail++;
            $display("FAIL lsb_order: got 0x%0h, required 0x%0h", mon_got, mon_exp);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, required %b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_alu(input logic [3:0] p, input logic [31:0] v);
    alu_q.push_back({p, v});
  endtask

  task automatic expect_lsb(input logic [3:0] p, input logic [31:0] v);
    lsb_q.push_back({p, v});
  endtask

  // Drive one cycle of inputs (called at a negedge), return at the next negedge.
  task automatic step(input logic a, input logic [3:0] ap, input logic [31:0] av,
                      input logic l, input logic [3:0] lp, input logic [31:0] lv);
    alu_result = a;  alu_result_rob_pos = ap;  alu_result_val = av;
    lsb_result = l;  lsb_result_rob_pos = lp;  lsb_result_val = lv;
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
  endtask

  task automatic do_reset(input logic rdy_during);
    rst = 1'b1;  rdy = rdy_during;  rollback = 1'b0;
    idle();
    idle();
    rst = 1'b0;  rdy = 1'b1;
    alu_q.delete();
    lsb_q.delete();
  endtask

  task automatic drain(input string name);
    int k = 0;
    while ((alu_q.size() != 0 || lsb_q.size() != 0) && k < 20) begin
      idle();
      k++;
    end
    n_checks++;
    if (alu_q.size() != 0 || lsb_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: %0d ALU + %0d LSB entries pending after %0d cycles, required 0",
               name, alu_q.size(), lsb_q.size(), k);
    end
    idle();
    chk1({name, "_idle_valid"}, cdb_valid, 1'b0);
  endtask

  task automatic test_single();
    expect_alu(4'd3, 32'h11);
    step(1'b1, 4'd3, 32'h11, 1'b0, 4'd0, 32'd0);
    chk1("single_no_bypass", cdb_valid, 1'b0);
    idle();
    chk1("single_valid", cdb_valid, 1'b1);
    chk32("single_pos", 32'(cdb_rob_pos), 32'd3);
    chk32("single_val", cdb_val, 32'h11);
    chk1("single_src", cdb_src, 1'b0);
    idle();
    chk1("single_valid_drop", cdb_valid, 1'b0);
    chk32("single_pos_hold", 32'(cdb_rob_pos), 32'd3);
    drain("single");
  endtask

  task automatic test_stream();
    do_reset(1'b1);
`ifdef CDB_ROUND_ROBIN_EN
    for (int i = 0; i < 6; i++) begin
      expect_alu(4'(i), 32'hA0 + 32'(i));
      expect_lsb(4'(i + 8), 32'hB0 + 32'(i));
      step(1'b1, 4'(i), 32'hA0 + 32'(i), 1'b1, 4'(i + 8), 32'hB0 + 32'(i));
      chk1("rr_ovf", ovf, 1'b0);
      chk1("rr_valid", cdb_valid, i >= 1);
      if (i >= 1) chk1("rr_src", cdb_src, (i % 2) == 0);
    end
    for (int j = 0; j < 8; j++) begin
      idle();
      chk1("rr_drain_valid", cdb_valid, j < 7);
      if (j < 7) chk1("rr_drain_src", cdb_src, (j % 2) == 0);
    end
`else
    for (int i = 0; i < 8; i++) begin
      if (i < 4) expect_alu(4'(i), 32'hA0 + 32'(i));
      expect_lsb(4'(i + 8), 32'hB0 + 32'(i));
      step(1'b1, 4'(i), 32'hA0 + 32'(i), 1'b1, 4'(i + 8), 32'hB0 + 32'(i));
      chk1("fp_alu_full", alu_full, i >= 3);
      chk1("fp_ovf", ovf, i >= 4);
      chk1("fp_valid", cdb_valid, i >= 1);
      if (i >= 1) chk1("fp_src", cdb_src, 1'b1);
    end
    for (int j = 0; j < 6; j++) begin
      idle();
      chk1("fp_drain_valid", cdb_valid, j < 5);
      if (j < 5) chk1("fp_drain_src", cdb_src, j == 0);
    end
    chk1("fp_ovf_sticky", ovf, 1'b1);
`endif
    drain("stream");
  endtask

  task automatic test_full_pushpop();
    do_reset(1'b1);
    for (int i = 0; i < FILL_N; i++) begin
      expect_alu(4'(i), 32'hC0 + 32'(i));
      expect_lsb(4'(i + 8), 32'hD0 + 32'(i));
      step(1'b1, 4'(i), 32'hC0 + 32'(i), 1'b1, 4'(i + 8), 32'hD0 + 32'(i));
    end
`ifndef CDB_ROUND_ROBIN_EN
    idle();
`endif
    chk1("pp_pre_full", alu_full, 1'b1);
    chk1("pp_pre_src", cdb_src, 1'b1);
    expect_alu(4'(FILL_N), 32'hC0 + 32'(FILL_N));
    step(1'b1, 4'(FILL_N), 32'hC0 + 32'(FILL_N), 1'b0, 4'd0, 32'd0);
    chk1("pp_full_kept", alu_full, 1'b1);
    chk1("pp_no_ovf", ovf, 1'b0);
    chk1("pp_src", cdb_src, 1'b0);
    chk32("pp_pos", 32'(cdb_rob_pos), POP_POS);
    drain("pushpop");
    chk1("pp_no_ovf_end", ovf, 1'b0);
  endtask

  task automatic test_rollback();
    do_reset(1'b1);
`ifdef CDB_ROUND_ROBIN_EN
    expect_alu(4'd1, 32'h201);
`else
    expect_lsb(4'd9, 32'h209);
`endif
    step(1'b1, 4'd1, 32'h201, 1'b1, 4'd9, 32'h209);
    step(1'b1, 4'd2, 32'h202, 1'b1, 4'd10, 32'h20A);
    chk1("rb_pre_valid", cdb_valid, 1'b1);
    chk32("rb_pre_pos", 32'(cdb_rob_pos), FIRST_POS);
    rollback = 1'b1;
    step(1'b1, 4'd14, 32'hDEAD, 1'b1, 4'd15, 32'hBEEF);
    rollback = 1'b0;
    chk1("rb_valid", cdb_valid, 1'b0);
    chk1("rb_alu_full", alu_full, 1'b0);
    for (int k = 0; k < 3; k++) begin
      idle();
      chk1("rb_quiet", cdb_valid, 1'b0);
    end
    expect_alu(4'd5, 32'h55);
    step(1'b1, 4'd5, 32'h55, 1'b0, 4'd0, 32'd0);
    chk1("rb_latency", cdb_valid, 1'b0);
    idle();
    chk1("rb_post_valid", cdb_valid, 1'b1);
    chk32("rb_post_pos", 32'(cdb_rob_pos), 32'd5);
    chk32("rb_post_val", cdb_val, 32'h55);
    drain("rollback");
  endtask

  task automatic test_freeze();
    do_reset(1'b1);
    expect_alu(4'd1, 32'h301);
    step(1'b1, 4'd1, 32'h301, 1'b0, 4'd0, 32'd0);
    expect_alu(4'd2, 32'h302);
    expect_lsb(4'd9, 32'h309);
    step(1'b1, 4'd2, 32'h302, 1'b1, 4'd9, 32'h309);
    chk32("fz_pre_pos", 32'(cdb_rob_pos), 32'd1);
    rdy = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 4'd15, 32'hBAD, 1'b1, 4'd15, 32'hBAD);
      chk1("fz_valid", cdb_valid, 1'b1);
      chk32("fz_pos", 32'(cdb_rob_pos), 32'd1);
      chk32("fz_val", cdb_val, 32'h301);
      chk1("fz_src", cdb_src, 1'b0);
    end
    rdy = 1'b1;
    idle();
    chk1("fz_resume_src0", cdb_src, 1'b1);
    chk32("fz_resume_pos0", 32'(cdb_rob_pos), 32'd9);
    idle();
    chk1("fz_resume_src1", cdb_src, 1'b0);
    chk32("fz_resume_pos1", 32'(cdb_rob_pos), 32'd2);
    drain("freeze");
  endtask

  initial begin
    rst = 1'b1;  rdy = 1'b0;  rollback = 1'b0;
    alu_result = 1'b0;  alu_result_rob_pos = 4'd0;  alu_result_val = 32'd0;
    lsb_result = 1'b0;  lsb_result_rob_pos = 4'd0;  lsb_result_val = 32'd0;
    @(negedge clk);
    do_reset(1'b0);
    chk1("rst_valid", cdb_valid, 1'b0);
    chk32("rst_pos", 32'(cdb_rob_pos), 32'd0);
    chk32("rst_val", cdb_val, 32'd0);
    chk1("rst_src", cdb_src, 1'b0);
    chk1("rst_ovf", ovf, 1'b0);
    chk1("rst_alu_full", alu_full, 1'b0);
    chk1("rst_lsb_full", lsb_full, 1'b0);
    test_single();
    test_stream();
    test_full_pushpop();
    test_rollback();
    test_freeze();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
